// File: rtl/ofmap_pingpong_buf.sv
// Two-bank output-feature-map buffer: the PPU fills one bank while the other drains.
// Banks are committed by i_wr_last and drained strictly in commit order, one beat every two cycles.
module ofmap_pingpong_buf #(
  parameter  int LANES = 16,
  parameter  int DW    = 4,
  parameter  int DEPTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [LANES*DW-1:0]   i_data,
  input  logic                  i_wr_last,
  output logic                  o_wr_ready,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [LANES*DW-1:0]   o_rd_data,
  output logic [AW-1:0]         o_rd_addr,
  output logic                  o_rd_last,
  output logic                  o_err_ovf
);

  localparam int WW = LANES * DW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } rd_state_e;

  rd_state_e     r_state;
  rd_state_e     w_state_nxt;

  logic [WW-1:0] r_mem0 [DEPTH];
  logic [WW-1:0] r_mem1 [DEPTH];

  logic          r_wb;
  logic          r_rb;
  logic [1:0]    r_full;
  logic [AW:0]   r_len [2];
  logic [AW-1:0] r_ra;
  logic          r_err;
  logic [WW-1:0] r_rd_data;

  logic          w_wr_ready;
  logic [AW:0]   w_addr_p1;
  logic [AW:0]   w_len_upd;
  logic          w_we_ok;
  logic          w_commit;
  logic          w_drop;
  logic          w_hs;
  logic          w_last;
  logic          w_release;

  // Write side: a same-cycle write is folded into len before the commit decision.
  always_comb begin
    w_wr_ready = ~r_full[r_wb];
    w_addr_p1  = {1'b0, i_addr} + (AW+1)'(1);
    w_len_upd  = r_len[r_wb];
    if (i_we && (w_addr_p1 > r_len[r_wb])) begin
      w_len_upd = w_addr_p1;
    end
    w_we_ok  = i_we & w_wr_ready;
    w_commit = i_wr_last & w_wr_ready & (w_len_upd != '0);
    w_drop   = (i_we | i_wr_last) & ~w_wr_ready;
  end

  always_comb begin
    w_hs      = (r_state == S_HOLD) & i_rd_ready;
    w_last    = ({1'b0, r_ra} == (r_len[r_rb] - (AW+1)'(1)));
    w_release = w_hs & w_last;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_full[r_rb]) w_state_nxt = S_FETCH;
      S_FETCH: w_state_nxt = S_HOLD;
      S_HOLD:  if (w_hs) w_state_nxt = w_last ? S_IDLE : S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The written bank is never full, the drained bank always is, so the
  // write and release updates below never touch the same bank in one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb     <= 1'b0;
      r_rb     <= 1'b0;
      r_full   <= '0;
      r_len[0] <= '0;
      r_len[1] <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_we_ok) begin
        r_len[r_wb] <= w_len_upd;
      end
      if (w_commit) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_drop) begin
        r_err <= 1'b1;
      end
      if (w_release) begin
        r_full[r_rb] <= 1'b0;
        r_len[r_rb]  <= '0;
        r_rb         <= ~r_rb;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ra <= '0;
    end else if (w_release || ((r_state == S_IDLE) && r_full[r_rb])) begin
      r_ra <= '0;
    end else if (w_hs) begin
      r_ra <= r_ra + AW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we_ok) begin
      if (r_wb) begin
        r_mem1[i_addr] <= i_data;
      end else begin
        r_mem0[i_addr] <= i_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (r_state == S_FETCH) begin
      r_rd_data <= r_rb ? r_mem1[r_ra] : r_mem0[r_ra];
    end
  end

  assign o_wr_ready = w_wr_ready;
  assign o_rd_valid = (r_state == S_HOLD);
  assign o_rd_data  = r_rd_data;
  assign o_rd_addr  = r_ra;
  assign o_rd_last  = (r_state == S_HOLD) & w_last;
  assign o_err_ovf  = r_err;

endmodule
